// File: rtl/qspi_line_fetcher.sv
// Quad-output (6Bh) SPI burst reader: shifts out CMD+ADDR on io0, waits the dummy
// clocks, then captures NIBBLE_COUNT nibbles from io[3:0] into a line buffer.
module qspi_line_fetcher #(
  parameter int          NIBBLE_COUNT = 136,
  parameter int          DUMMY_SCLKS  = 8,
  parameter logic [7:0]  SPI_CMD      = 8'h6B,
  parameter int          CS_GAP       = 2,
  parameter int          IDX_W        = $clog2(NIBBLE_COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      start_addr,
  output logic             busy,
  output logic             done,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [3:0]       rd_data,
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_out0,
  output logic             spi_dir0,
  input  logic [3:0]       spi_in
);

  localparam int CW = $clog2(NIBBLE_COUNT + 32 + DUMMY_SCLKS + CS_GAP + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [CW-1:0] CMD_LAST   = CW'(7);
  localparam logic [CW-1:0] ADDR_LAST  = CW'(23);
  localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY_SCLKS - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(NIBBLE_COUNT - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   shreg_q, shreg_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          dir0_q, dir0_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    rd_data_q;
  logic [3:0]    line_q [NIBBLE_COUNT];

  logic             we;
  logic [IDX_W-1:0] widx;
  logic             in_range;

  // A pulse ends when sclk is high; that edge both shifts io0 and samples io[3:0].
  assign we       = (state_q == S_DATA) && sclk_q;
  assign widx     = IDX_W'(cnt_q);
  assign in_range = ({1'b0, rd_idx} < (IDX_W+1)'(NIBBLE_COUNT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    dir0_d  = dir0_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = {SPI_CMD, start_addr};
          cs_d    = 1'b1;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          // Zero-fill means io0 is already 0 once all 32 header bits are out.
          shreg_d = {shreg_q[30:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
          case (state_q)
            S_CMD: if (cnt_q == CMD_LAST) begin
              state_d = S_ADDR;
              cnt_d   = '0;
            end
            S_ADDR: if (cnt_q == ADDR_LAST) begin
              state_d = S_DUMMY;
              cnt_d   = '0;
              dir0_d  = 1'b1;
            end
            S_DUMMY: if (cnt_q == DUMMY_LAST) begin
              state_d = S_DATA;
              cnt_d   = '0;
            end
            S_DATA: if (cnt_q == DATA_LAST) begin
              state_d = S_GAP;
              cnt_d   = '0;
              cs_d    = 1'b0;
              dir0_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_GAP: begin
        if (done_q) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == GAP_LAST) begin
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
      dir0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      dir0_q    <= dir0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= in_range ? line_q[rd_idx] : 4'h0;
    end
  end

  // Buffer keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (we) line_q[widx] <= spi_in;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign spi_cs   = cs_q;
  assign spi_sclk = sclk_q;
  assign spi_out0 = shreg_q[31];
  assign spi_dir0 = dir0_q;

endmodule

// File: doc/qspi_line_fetcher.md
Name: qspi_line_fetcher

Overview:
- Quad-output SPI (6Bh) burst reader that fetches one line's worth of nibbles from the SPI flash ROM into an internal line buffer.
- Sits directly upstream of the VGA pixel/colour logic. That logic triggers a fetch per line (e.g. at a fixed hpos) and reads nibbles back by index to paint pixels.
- Drives the generic SPI pad interface (spi_cs active HIGH, spi_out0/spi_dir0, spi_in[3:0]).
- Generates its own SCLK at clk/2, so everything runs in the single clk domain.

Parameters:
- NIBBLE_COUNT, 136, nibbles captured per fetch; also the buffer depth.
- DUMMY_SCLKS, 8, SCLK pulses between ADDR[0] and the first data nibble.
- SPI_CMD, 8'h6B, command byte shifted out MSB first.
- CS_GAP, 2, minimum clk cycles spi_cs stays low after a burst before done/idle.
- IDX_W, $clog2(NIBBLE_COUNT), buffer index width.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  ASYNCHRONOUS, ACTIVE-LOW reset (0 = reset asserted).
- start  in  1  single-cycle fetch request; honoured only when busy==0.
- start_addr  in  24  flash byte address, latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse at the end of CS_GAP.
- rd_idx  in  IDX_W  buffer read index.
- rd_data  out  4  nibble at rd_idx, registered (1-cycle latency).
- spi_cs  out  1  chip select, active HIGH (parent inverts).
- spi_sclk  out  1  SCLK, mode 0 (idles low).
- spi_out0  out  1  io0 output value (MOSI during CMD/ADDR).
- spi_dir0  out  1  io0 direction, 0 = output, 1 = input.
- spi_in  in  4  io[3:0] input side.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; busy=0, done=0, spi_cs=0, spi_sclk=0, spi_out0=0, spi_dir0=0, rd_data=0.
  - Buffer contents are not cleared.
- Reset during a burst drops spi_cs and spi_sclk immediately. Operation resumes in IDLE after reset deasserts.
- States: IDLE -> CMD(8 SCLK) -> ADDR(24) -> DUMMY(DUMMY_SCLKS) -> DATA(NIBBLE_COUNT) -> GAP(CS_GAP clks) -> IDLE.
- Start acceptance:
  - start with busy==0 latches start_addr and SPI_CMD into a 32-bit shift register.
  - start while busy==1 is ignored: no queueing, no effect on the running burst.
- SCLK generation:
  - The cycle after acceptance: spi_cs=1, spi_sclk=0, spi_out0=CMD[7].
  - spi_sclk toggles every clk while in CMD..DATA, so each SCLK pulse is 2 clks (low phase, then high phase).
- io0 output:
  - spi_out0 changes only on the clk edge where spi_sclk goes 1->0, presenting the next bit of {CMD, ADDR[23:0]} MSB first.
  - From DUMMY onward spi_out0=0.
  - spi_dir0=0 through the high phase of ADDR[0]; spi_dir0=1 from the first DUMMY low phase to the end of DATA.
  - spi_dir0=0 in GAP and IDLE.
- Data capture:
  - spi_in is sampled on the clk edge ending each DATA high phase, i.e. the edge where spi_sclk goes 1->0.
  - Nibble k (0-based, first received = k=0) is written to buffer[k], with spi_in[3] as the MSB.
  - The write counter stops at NIBBLE_COUNT-1; there is no wrap and no overrun.
- CS timing:
  - spi_cs is high for exactly 2*(32+DUMMY_SCLKS+NIBBLE_COUNT) clks; default 352.
  - spi_cs falls together with the final spi_sclk 1->0.
  - spi_sclk is 0 whenever spi_cs is 0.
- Completion: after CS_GAP clks with spi_cs=0, done=1 for one cycle (busy still 1 in that cycle), then busy=0.
  - start may be accepted in the cycle after done.
- Default latency, start accepted at cycle 0: spi_cs rises at 1, falls at 353, done at 355.
- Read port:
  - rd_data <= buffer[rd_idx] every clk, including while busy.
  - A read in the same cycle as a write to that index returns the old value.
  - rd_idx >= NIBBLE_COUNT returns 4'h0.

Test Plan:
- Reset mid-DATA (reset low at cycle 200 after start): spi_cs=0, spi_sclk=0 and busy=0 immediately. After release, a new start is accepted and the burst completes normally.
- Command/address framing: start_addr=24'h0012C0 -> io0 over 32 SCLK rises reads 0x6B then 0x0012C0 MSB first. spi_dir0 flips to 1 at the first DUMMY low phase. spi_cs stays high for exactly 352 clks. done pulses at cycle 355.
- Data capture: flash model drives nibble k = k[3:0] starting after 8 dummy SCLKs -> rd_idx=0..135 returns 0,1,...,F,0,... and rd_idx=135 returns 4'h7. rd_data lags rd_idx by exactly 1 clk.
- Busy rule: start pulsed at cycles 0, 50 and 355 with different addresses -> cycle 50 is ignored (no CS glitch, address unchanged). Cycle 355 is ignored because busy==1 there. start at 356 is accepted.
- Boundary reads: rd_idx=136 or 255 -> rd_data=0. Reading index 5 in the cycle it is written returns the previous fetch's value, and the new value on the next read.
- Mode-0 check: across a full burst, spi_out0 never changes while spi_sclk==1, and spi_sclk==0 throughout IDLE and GAP.
